// File: rtl/tap_gesture_decoder_if.sv
// Pulse-in / gesture-out bundle between the button debouncer, the tap decoder
// and the UI logic. The tap_count width follows MAX_TAPS.
interface tap_gesture_decoder_if #(
  parameter int MAX_TAPS = 3
);
  logic                             pulse_in;
  logic                             tap_valid;
  logic [$clog2(MAX_TAPS + 1)-1:0]  tap_count;
  logic                             busy;

  modport master (output pulse_in, input tap_valid, tap_count, busy);
  modport slave  (input pulse_in, output tap_valid, tap_count, busy);
endinterface

// File: rtl/tap_gesture_decoder.sv
// Groups debounced press pulses into tap gestures closed by an inter-tap timeout
// or by reaching MAX_TAPS. Optional post-event holdoff enabled by TAP_HOLDOFF_EN.
module tap_gesture_decoder #(
  parameter int WINDOW_CYCLES  = 8,
  parameter int MAX_TAPS       = 3,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tap_gesture_decoder_if.slave  bus
);

  localparam int TIMER_W = $clog2(WINDOW_CYCLES);
  localparam int COUNT_W = $clog2(MAX_TAPS + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(MAX_TAPS);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("tap_gesture_decoder: WINDOW_CYCLES must be at least 2");
  end
  if (MAX_TAPS < 1) begin : g_bad_max_taps
    $error("tap_gesture_decoder: MAX_TAPS must be at least 1");
  end
  if (HOLDOFF_CYCLES < 0) begin : g_bad_holdoff
    $error("tap_gesture_decoder: HOLDOFF_CYCLES must not be negative");
  end

`ifdef TAP_HOLDOFF_EN
  typedef enum logic [1:0] {IDLE, COUNT, EMIT, HOLDOFF} state_t;

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 1 : 0);

  logic [HOLD_W-1:0] hold;
`else
  typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;
`endif

  state_t              state;
  logic [COUNT_W-1:0]  count;
  logic [TIMER_W-1:0]  timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      timer         <= '0;
      bus.tap_valid <= 1'b0;
      bus.tap_count <= '0;
      bus.busy      <= 1'b0;
`ifdef TAP_HOLDOFF_EN
      hold          <= '0;
`endif
    end else begin
      bus.tap_valid <= 1'b0;
      case (state)
        // A pulse always wins over the timeout check on the same edge.
        COUNT: begin
          if (bus.pulse_in) begin
            timer <= '0;
            if (count + COUNT_ONE == COUNT_MAX) begin
              count         <= COUNT_MAX;
              state         <= EMIT;
              bus.tap_valid <= 1'b1;
              bus.tap_count <= COUNT_MAX;
            end else begin
              count <= count + COUNT_ONE;
            end
          end else if (timer == TIMER_LAST) begin
            timer         <= '0;
            state         <= EMIT;
            bus.tap_valid <= 1'b1;
            bus.tap_count <= count;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

`ifdef TAP_HOLDOFF_EN
        // The edge after EMIT is the first ignored edge of the holdoff period.
        EMIT: begin
          if (HOLDOFF_CYCLES > 1) begin
            state <= HOLDOFF;
            hold  <= HOLD_W'(1);
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        HOLDOFF: begin
          if (hold >= HOLD_LAST) begin
            state    <= IDLE;
            hold     <= '0;
            bus.busy <= 1'b0;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
`endif

        // IDLE, and EMIT when there is no holdoff, so a pulse right after an event is kept.
        default: begin
          if (bus.pulse_in) begin
            count    <= COUNT_ONE;
            timer    <= '0;
            bus.busy <= 1'b1;
            if (MAX_TAPS == 1) begin
              state         <= EMIT;
              bus.tap_valid <= 1'b1;
              bus.tap_count <= COUNT_ONE;
            end else begin
              state <= COUNT;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_gesture_decoder.sv
// Self-checking bench for tap_gesture_decoder: directed gesture scenarios plus
// random pulse traffic, compared edge by edge against a timing-rule model.
module tb_tap_gesture_decoder;

  localparam int W  = 8;
  localparam int MT = 3;
  localparam int H  = 4;
  localparam int CW = $clog2(MT + 1);

  logic clk;
  logic rst;

  tap_gesture_decoder_if #(.MAX_TAPS(MT)) bus ();

  tap_gesture_decoder #(
    .WINDOW_CYCLES (W),
    .MAX_TAPS      (MT),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: described by edge numbers, not by the decoder's states.
  int            edge_n     = 0;
  bit            active     = 1'b0;
  int            taps       = 0;
  int            last_pulse = 0;
  int            last_emit  = -1000;
  logic          exp_valid  = 1'b0;
  logic [CW-1:0] exp_count  = '0;
  logic          exp_busy   = 1'b0;

  function automatic void emitNow();
    active    = 1'b0;
    exp_valid = 1'b1;
    exp_count = CW'(taps);
    last_emit = edge_n;
  endfunction

  function automatic bit inHoldoff();
`ifdef TAP_HOLDOFF_EN
    return (edge_n - last_emit >= 1) && (edge_n - last_emit <= H);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput();
    n_checks++;
    assert (bus.tap_valid === exp_valid) else begin
      n_errors++;
      $error("[TB] FAIL tap_valid edge %0d: observed %0b expected %0b", edge_n, bus.tap_valid, exp_valid);
    end
    n_checks++;
    assert (bus.tap_count === exp_count) else begin
      n_errors++;
      $error("[TB] FAIL tap_count edge %0d: observed %0d expected %0d", edge_n, bus.tap_count, exp_count);
    end
    n_checks++;
    assert (bus.busy === exp_busy) else begin
      n_errors++;
      $error("[TB] FAIL busy edge %0d: observed %0b expected %0b", edge_n, bus.busy, exp_busy);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic r);
    bus.pulse_in = p;
    rst          = r;
    @(posedge clk);
    edge_n++;
    exp_valid = 1'b0;
    if (r) begin
      active    = 1'b0;
      taps      = 0;
      exp_count = '0;
      last_emit = -1000;
    end else if (active) begin
      if (p) begin
        taps++;
        last_pulse = edge_n;
        if (taps == MT) emitNow();
      end else if (edge_n - last_pulse == W) begin
        emitNow();
      end
    end else if (p && !inHoldoff()) begin
      active     = 1'b1;
      taps       = 1;
      last_pulse = edge_n;
      if (taps == MT) emitNow();
    end
`ifdef TAP_HOLDOFF_EN
    exp_busy = active || (edge_n - last_emit < ((H > 1) ? H : 1));
`else
    exp_busy = active || (edge_n == last_emit);
`endif
    #1;
    checkOutput();
  endtask

  task automatic idleEdges(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    bus.pulse_in = 1'b0;
    rst          = 1'b1;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    idleEdges(5);

    $display("[TB] single tap");
    applyStimulus(1'b1, 1'b0);
    idleEdges(12);

    $display("[TB] double tap, gap 4");
    applyStimulus(1'b1, 1'b0);
    idleEdges(3);
    applyStimulus(1'b1, 1'b0);
    idleEdges(12);

    $display("[TB] triple tap back-to-back");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idleEdges(18);

    $display("[TB] double tap, gap 7");
    applyStimulus(1'b1, 1'b0);
    idleEdges(6);
    applyStimulus(1'b1, 1'b0);
    idleEdges(12);

    $display("[TB] pulse on the timeout edge");
    applyStimulus(1'b1, 1'b0);
    idleEdges(7);
    applyStimulus(1'b1, 1'b0);
    idleEdges(12);

    $display("[TB] reset mid-gesture");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idleEdges(12);

    $display("[TB] pulse on the edge after an event");
    applyStimulus(1'b1, 1'b0);
    idleEdges(8);
    applyStimulus(1'b1, 1'b0);
    idleEdges(12);

    $display("[TB] reset on the event edge");
    applyStimulus(1'b1, 1'b0);
    idleEdges(7);
    applyStimulus(1'b0, 1'b1);
    idleEdges(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      logic p;
      logic r;
      p = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 149) == 0);
      applyStimulus(p, r);
    end
    idleEdges(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
